sha_out_seq: RTL and testbench
==============================

Name: sha_out_seq

Overview:
Sequencer for the SHA digest output path. It accepts the 32-bit digest words streamed from the SHA core over a valid/ready handshake and drives the shift-enable of the 8-word serial-to-parallel shift register (stp_sr_8). It counts the words, tags the assembled 256-bit hash with the nonce that produced it, and presents a hash-valid/ack handshake to the downstream target comparator. It also provides abort, overrun detection and a completed-hash counter.

Parameters:
NWORDS, 8, digest words per hash; must match the shift-register depth.
CNT_W, 4, word counter width; must be at least clog2(NWORDS+1).

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
word_valid  in  1  SHA core presents a digest word
word_in  in  32  digest word from the SHA core
word_ready  out  1  sequencer can accept a word this cycle
nonce_in  in  32  nonce associated with the word stream currently being emitted
abort  in  1  discard the partial or complete hash and return to IDLE
sr_shift_enable  out  1  drives stp_sr_8 shift_enable
sr_serial_in  out  32  drives stp_sr_8 serial_in; equals word_in (combinational pass-through)
hash_valid  out  1  stp_sr_8 parallel_out holds a complete hash
hash_ack  in  1  downstream has consumed the hash
nonce_out  out  32  nonce tag for the presented hash
word_count  out  CNT_W  words accepted for the current hash
hash_count  out  32  completed hashes acknowledged; wraps modulo 2^32
err_overrun  out  1  sticky flag: word_valid was asserted while the hash was full
clr_err  in  1  synchronous clear for err_overrun

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, word_count=0, hash_valid=0, nonce_out=0, hash_count=0, err_overrun=0.
- accept = word_valid & word_ready. sr_shift_enable = accept (combinational, same cycle). Each accepted word is shifted into the shift register on that clock edge.
- FSM states:
  - IDLE: word_ready=1. On accept: latch nonce_in into nonce_out, set word_count=1, go to COLLECT. If NWORDS=1, go directly to FULL.
  - COLLECT: word_ready=1. On accept: word_count+1. When the accepted word is word NWORDS, go to FULL.
  - FULL: word_ready=0, hash_valid=1, word_count=NWORDS.
    - hash_ack=1 in FULL: go to IDLE next cycle, word_count=0, hash_count+1.
    - word_ready stays 0 in the ack cycle, so a new word is accepted no earlier than the following cycle.
- Latency: hash_valid rises in the cycle after the edge that shifts in the last word. parallel_out is stable from that cycle until the ack is taken.
- hash_valid is registered and equals (state==FULL). The bench checks this relationship continuously.
- hash_ack outside FULL is ignored.
- word_valid=0 in COLLECT: hold state and count. There is no timeout.
- abort: has priority over every other event in the same cycle.
  - Next cycle: state=IDLE, word_count=0, hash_valid=0.
  - hash_count is unchanged, including when abort and hash_ack are asserted together.
  - sr_shift_enable is forced to 0 in the abort cycle, so a simultaneous word is dropped.
  - nonce_out holds its value until the next first-word latch.
- err_overrun: set when state==FULL and word_valid=1. It is sticky. clr_err clears it; if set and clear occur in the same cycle, set wins.
- hash_count: increments only on an acked FULL and wraps from 0xFFFFFFFF to 0.
- The shift register is never cleared by this block. Stale contents are overwritten by the next NWORDS shifts.
- Reset mid-operation: all state returns to reset values immediately, and any partial hash is discarded.

Test Plan:
- Basic hash: reset, then 8 back-to-back valid words 0x00000001..0x00000008 with nonce_in=0xDEADBEEF on word 1.
  - sr_shift_enable is high for exactly 8 cycles.
  - hash_valid rises 1 cycle after word 8, with parallel_out word0=0x00000008 and word7=0x00000001.
  - nonce_out=0xDEADBEEF, word_count=8.
- Ack and back-pressure: hold hash_ack=0 for 5 cycles with word_valid=1.
  - word_ready=0 throughout, err_overrun=1.
  - Then assert hash_ack: IDLE next cycle, hash_count=1, clr_err drops err_overrun to 0.
- Gapped input: 8 words with word_valid low on alternate cycles.
  - word_count steps 1..8 only on accepted cycles.
  - hash_valid occurs 1 cycle after the 8th accept.
- Abort mid-stream: abort after 3 words, asserted together with word_valid.
  - No shift in the abort cycle; word_count=0 next cycle.
  - A following 8-word stream latches the new nonce.
- Abort vs ack collision: in FULL, assert abort and hash_ack in the same cycle.
  - Next cycle IDLE, hash_valid=0, hash_count unchanged.
- Reset mid-collect: drive n_rst low asynchronously (mid-cycle) after 5 words.
  - All outputs go to reset values immediately.
  - After release, a full 8-word stream yields hash_valid with hash_count=0 before the ack.

Source files
------------

// File: rtl/sha_out_seq_if.sv
//------------------------------------------------------------------------------
// Module   : sha_out_seq_if
// Purpose  : Bundles the SHA digest-word handshake, the shift-register drive
//            and the hash-valid/ack handshake used by sha_out_seq.
// Ports    : word_valid/word_in/word_ready/nonce_in - digest word stream in
//            abort, clr_err                           - control
//            sr_shift_enable/sr_serial_in             - stp_sr_8 drive
//            hash_valid/hash_ack/nonce_out            - downstream handshake
//            word_count/hash_count/err_overrun        - status
// Modports : master - producer/consumer side; slave - the sequencer itself
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sha_out_seq_if #(
  parameter int CNT_W = 4
);
  logic             word_valid;
  logic [31:0]      word_in;
  logic             word_ready;
  logic [31:0]      nonce_in;
  logic             abort;
  logic             sr_shift_enable;
  logic [31:0]      sr_serial_in;
  logic             hash_valid;
  logic             hash_ack;
  logic [31:0]      nonce_out;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      hash_count;
  logic             err_overrun;
  logic             clr_err;

  modport master (
    output word_valid, word_in, nonce_in, abort, hash_ack, clr_err,
    input  word_ready, sr_shift_enable, sr_serial_in, hash_valid,
           nonce_out, word_count, hash_count, err_overrun
  );

  modport slave (
    input  word_valid, word_in, nonce_in, abort, hash_ack, clr_err,
    output word_ready, sr_shift_enable, sr_serial_in, hash_valid,
           nonce_out, word_count, hash_count, err_overrun
  );
endinterface

`default_nettype wire

// File: rtl/sha_out_seq.sv
//------------------------------------------------------------------------------
// Module   : sha_out_seq
// Purpose  : Output sequencer for the SHA digest path. Accepts NWORDS digest
//            words, drives the serial-to-parallel shift register, tags the
//            completed hash with its nonce and hands it downstream through a
//            hash_valid/hash_ack handshake. Provides abort, a sticky overrun
//            flag and a completed-hash counter.
// Ports    : clk   - system clock, rising edge
//            n_rst - asynchronous active-low reset
//            bus   - sha_out_seq_if.slave (see interface for signal list)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sha_out_seq #(
  parameter int NWORDS = 8,
  parameter int CNT_W  = 4
) (
  input  wire logic    clk,
  input  wire logic    n_rst,
  sha_out_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_word_count;
  logic             r_hash_valid;
  logic [31:0]      r_nonce_out;
  logic [31:0]      r_hash_count;
  logic             r_err_overrun;

  logic             w_ready;
  logic             w_accept;
  logic             w_ack_taken;

  // Abort suppresses acceptance so a word arriving with abort never shifts.
  assign w_ready     = (r_state != S_FULL);
  assign w_accept    = bus.word_valid & w_ready & ~bus.abort;
  assign w_ack_taken = (r_state == S_FULL) & bus.hash_ack & ~bus.abort;

  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt = (NWORDS == 1) ? S_FULL : S_COLLECT;
          end
        end
        S_COLLECT: begin
          // The word being accepted now is the last one of the hash.
          if (w_accept && (r_word_count == c_last_idx)) begin
            w_state_nxt = S_FULL;
          end
        end
        S_FULL: begin
          if (bus.hash_ack) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // hash_valid is registered from the next state so it tracks state==FULL
  // exactly without any combinational path to the downstream comparator.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hash_valid <= 1'b0;
    end else begin
      r_hash_valid <= (w_state_nxt == S_FULL);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_word_count <= '0;
    end else if (bus.abort) begin
      r_word_count <= '0;
    end else if (w_accept) begin
      r_word_count <= (r_state == S_IDLE) ? c_one : (r_word_count + c_one);
    end else if (w_ack_taken) begin
      r_word_count <= '0;
    end
  end

  // Nonce is tagged on the first word only and survives abort untouched.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_nonce_out <= '0;
    end else if (w_accept && (r_state == S_IDLE)) begin
      r_nonce_out <= bus.nonce_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hash_count <= '0;
    end else if (w_ack_taken) begin
      r_hash_count <= r_hash_count + 32'd1;
    end
  end

  // Set has priority over clear so an overrun in the clear cycle is kept.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_err_overrun <= 1'b0;
    end else if ((r_state == S_FULL) && bus.word_valid) begin
      r_err_overrun <= 1'b1;
    end else if (bus.clr_err) begin
      r_err_overrun <= 1'b0;
    end
  end

  assign bus.word_ready      = w_ready;
  assign bus.sr_shift_enable = w_accept;
  assign bus.sr_serial_in    = bus.word_in;
  assign bus.hash_valid      = r_hash_valid;
  assign bus.nonce_out       = r_nonce_out;
  assign bus.word_count      = r_word_count;
  assign bus.hash_count      = r_hash_count;
  assign bus.err_overrun     = r_err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sha_out_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_sha_out_seq
// Purpose  : Self-checking bench for sha_out_seq. A word-list reference model
//            and a model of the external 8-word shift register track the
//            expected outputs; scenario tasks add targeted checks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sha_out_seq;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sha_out_seq_if #(.CNT_W(4)) bus ();

  sha_out_seq #(.NWORDS(NW), .CNT_W(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: list of words accepted for the hash being built.
  logic [31:0] q[$];
  logic [31:0] m_nonce = '0;
  logic [31:0] m_hc    = '0;
  bit          m_err   = 1'b0;
  logic [31:0] sr_model [NW];
  bit          shift_seen = 1'b0;
  logic [31:0] serial_seen = '0;

  // External stp_sr_8 model: word0 is the newest, word NW-1 the oldest.
  always @(posedge clk) begin
    if (n_rst && shift_seen) begin
      for (int i = NW - 1; i > 0; i--) sr_model[i] = sr_model[i-1];
      sr_model[0] = serial_seen;
    end
  end

  // Model update from the spec rules, using only the driven inputs.
  always @(posedge clk) begin
    if (n_rst) begin
      bit full_before;
      full_before = (q.size() == NW);
      if (full_before && bus.word_valid) m_err = 1'b1;
      else if (bus.clr_err)              m_err = 1'b0;
      if (bus.abort) begin
        q.delete();
      end else if (full_before) begin
        if (bus.hash_ack) begin
          q.delete();
          m_hc = m_hc + 32'd1;
        end
      end else if (bus.word_valid) begin
        if (q.size() == 0) m_nonce = bus.nonce_in;
        q.push_back(bus.word_in);
      end
    end
  end

  // Continuous output monitor: registered outputs at negedge, combinational
  // outputs after the inputs for the cycle have settled.
  always @(negedge clk) begin
    if (n_rst) begin
      total++;
      if (bus.hash_valid !== (q.size() == NW)) begin
        bad++; $display("FAIL mon_hash_valid got=%0b exp=%0b", bus.hash_valid, (q.size() == NW));
      end
      total++;
      if (bus.word_count !== 4'(q.size())) begin
        bad++; $display("FAIL mon_word_count got=%0d exp=%0d", bus.word_count, q.size());
      end
      total++;
      if (bus.nonce_out !== m_nonce) begin
        bad++; $display("FAIL mon_nonce_out got=%h exp=%h", bus.nonce_out, m_nonce);
      end
      total++;
      if (bus.hash_count !== m_hc) begin
        bad++; $display("FAIL mon_hash_count got=%0d exp=%0d", bus.hash_count, m_hc);
      end
      total++;
      if (bus.err_overrun !== m_err) begin
        bad++; $display("FAIL mon_err_overrun got=%0b exp=%0b", bus.err_overrun, m_err);
      end
      if (q.size() == NW) begin
        for (int i = 0; i < NW; i++) begin
          total++;
          if (sr_model[i] !== q[NW-1-i]) begin
            bad++; $display("FAIL mon_parallel_out[%0d] got=%h exp=%h", i, sr_model[i], q[NW-1-i]);
          end
        end
      end
      #2;
      if (n_rst) begin
        total++;
        if (bus.word_ready !== (q.size() != NW)) begin
          bad++; $display("FAIL mon_word_ready got=%0b exp=%0b", bus.word_ready, (q.size() != NW));
        end
        total++;
        if (bus.sr_shift_enable !== (bus.word_valid && (q.size() != NW) && !bus.abort)) begin
          bad++; $display("FAIL mon_shift_enable got=%0b exp=%0b", bus.sr_shift_enable,
                          (bus.word_valid && (q.size() != NW) && !bus.abort));
        end
        total++;
        if (bus.sr_serial_in !== bus.word_in) begin
          bad++; $display("FAIL mon_serial_in got=%h exp=%h", bus.sr_serial_in, bus.word_in);
        end
        shift_seen  = bus.sr_shift_enable;
        serial_seen = bus.sr_serial_in;
      end
    end
  end

  // Drive one cycle of inputs shortly after the falling edge.
  task automatic step(input bit wv, input logic [31:0] w, input logic [31:0] n,
                      input bit ab, input bit ack, input bit clr);
    @(negedge clk);
    #1;
    bus.word_valid = wv;
    bus.word_in    = w;
    bus.nonce_in   = n;
    bus.abort      = ab;
    bus.hash_ack   = ack;
    bus.clr_err    = clr;
  endtask

  task automatic idle();
    step(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    m_nonce = '0;
    m_hc = '0;
    m_err = 1'b0;
    shift_seen = 1'b0;
  endtask

  task automatic test_reset();
    bus.word_valid = 0; bus.word_in = 0; bus.nonce_in = 0;
    bus.abort = 0; bus.hash_ack = 0; bus.clr_err = 0;
    n_rst = 1'b0;
    #12;
    total++;
    if (bus.hash_valid !== 1'b0 || bus.word_count !== 4'd0 || bus.nonce_out !== 32'd0 ||
        bus.hash_count !== 32'd0 || bus.err_overrun !== 1'b0 || bus.word_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got hv=%0b wc=%0d nonce=%h hc=%0d err=%0b rdy=%0b exp 0/0/0/0/0/1",
               bus.hash_valid, bus.word_count, bus.nonce_out, bus.hash_count, bus.err_overrun, bus.word_ready);
    end
    @(negedge clk);
    #4;
    n_rst = 1'b1;
  endtask

  task automatic test_basic();
    int shifts = 0;
    for (int i = 1; i <= NW; i++) begin
      step(1'b1, 32'(i), (i == 1) ? 32'hDEADBEEF : $urandom, 1'b0, 1'b0, 1'b0);
      #1;
      if (bus.sr_shift_enable) shifts++;
    end
    total++;
    if (bus.hash_valid !== 1'b0) begin
      bad++; $display("FAIL basic_hv_early got=%0b exp=0", bus.hash_valid);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      #1;
      if (bus.sr_shift_enable) shifts++;
    end
    total++;
    if (shifts != 8) begin
      bad++; $display("FAIL basic_shift_cycles got=%0d exp=8", shifts);
    end
    total++;
    if (bus.hash_valid !== 1'b1 || bus.word_count !== 4'd8 || bus.nonce_out !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic_hash got hv=%0b wc=%0d nonce=%h exp 1/8/deadbeef",
                      bus.hash_valid, bus.word_count, bus.nonce_out);
    end
    total++;
    if (sr_model[0] !== 32'd8 || sr_model[7] !== 32'd1) begin
      bad++; $display("FAIL basic_parallel got w0=%h w7=%h exp 8/1", sr_model[0], sr_model[7]);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (bus.word_ready !== 1'b0 || bus.sr_shift_enable !== 1'b0) begin
        bad++; $display("FAIL bp_ready got rdy=%0b se=%0b exp 0/0", bus.word_ready, bus.sr_shift_enable);
      end
    end
    step(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    #1;
    total++;
    if (bus.err_overrun !== 1'b1 || bus.sr_shift_enable !== 1'b0) begin
      bad++; $display("FAIL bp_overrun got err=%0b se=%0b exp 1/0", bus.err_overrun, bus.sr_shift_enable);
    end
    step(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.hash_valid !== 1'b0 || bus.word_count !== 4'd0 || bus.hash_count !== 32'd1) begin
      bad++; $display("FAIL bp_ack got hv=%0b wc=%0d hc=%0d exp 0/0/1",
                      bus.hash_valid, bus.word_count, bus.hash_count);
    end
    idle();
    total++;
    if (bus.err_overrun !== 1'b0) begin
      bad++; $display("FAIL bp_clr_err got=%0b exp=0", bus.err_overrun);
    end
  endtask

  task automatic test_gapped();
    for (int k = 1; k <= NW; k++) begin
      step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      step(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus.word_count !== 4'(k)) begin
        bad++; $display("FAIL gap_count got=%0d exp=%0d", bus.word_count, k);
      end
      total++;
      if (bus.hash_valid !== (k == NW)) begin
        bad++; $display("FAIL gap_hv got=%0b exp=%0b", bus.hash_valid, (k == NW));
      end
    end
    step(1'b0, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] n2;
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (bus.sr_shift_enable !== 1'b0) begin
      bad++; $display("FAIL abort_shift got=%0b exp=0", bus.sr_shift_enable);
    end
    idle();
    total++;
    if (bus.word_count !== 4'd0 || bus.hash_valid !== 1'b0) begin
      bad++; $display("FAIL abort_clear got wc=%0d hv=%0b exp 0/0", bus.word_count, bus.hash_valid);
    end
    n2 = $urandom;
    for (int i = 0; i < NW; i++) step(1'b1, $urandom, (i == 0) ? n2 : $urandom, 1'b0, 1'b0, 1'b0);
    idle();
    total++;
    if (bus.nonce_out !== n2 || bus.hash_valid !== 1'b1) begin
      bad++; $display("FAIL abort_renonce got nonce=%h hv=%0b exp %h/1", bus.nonce_out, bus.hash_valid, n2);
    end
    step(1'b0, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_collision();
    logic [31:0] hc0;
    for (int i = 0; i < NW; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    idle();
    hc0 = m_hc;
    step(1'b0, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
    idle();
    total++;
    if (bus.hash_valid !== 1'b0 || bus.word_ready !== 1'b1 || bus.hash_count !== hc0) begin
      bad++; $display("FAIL collision got hv=%0b rdy=%0b hc=%0d exp 0/1/%0d",
                      bus.hash_valid, bus.word_ready, bus.hash_count, hc0);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    n_rst = 1'b0;
    model_reset();
    bus.word_valid = 1'b0;
    #1;
    total++;
    if (bus.hash_valid !== 1'b0 || bus.word_count !== 4'd0 || bus.nonce_out !== 32'd0 ||
        bus.hash_count !== 32'd0 || bus.err_overrun !== 1'b0) begin
      bad++; $display("FAIL midreset got hv=%0b wc=%0d nonce=%h hc=%0d err=%0b exp all 0",
                      bus.hash_valid, bus.word_count, bus.nonce_out, bus.hash_count, bus.err_overrun);
    end
    @(negedge clk);
    #4;
    n_rst = 1'b1;
    for (int i = 0; i < NW; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    idle();
    total++;
    if (bus.hash_valid !== 1'b1 || bus.hash_count !== 32'd0) begin
      bad++; $display("FAIL midreset_rerun got hv=%0b hc=%0d exp 1/0", bus.hash_valid, bus.hash_count);
    end
    step(1'b0, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom, $urandom, ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
    end
    idle();
    idle();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) sr_model[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_abort();
    test_collision();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
